mem_wb_skid: RTL and testbench
==============================

# mem_wb_skid

Parametrised MEM/WB pipeline boundary with valid/ready flow control and a two-entry skid buffer. Sits between the memory-access stage and register/HI-LO/flags writeback. Carries the full writeback payload and allows writeback to back-pressure MEM without a combinational ready path, plus a stage flush and a saturating stall counter. Latency is one cycle; throughput is one beat per cycle.

## Interface
Parameters:
- `DATA_W`, 32: width of `wdata`, `hi`, `lo`.
- `ADDR_W`, 5: register-address width.
- `FLAGS_W`, 32: flags-register width.
- `CNT_W`, 16: stall-counter width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `flush`  in  1  discard all held beats (synchronous).
- `mem_valid`  in  1  MEM presents a beat.
- `mem_ready`  out  1  stage can accept a beat; driven only from flops.
- `mem_wd`  in  ADDR_W  destination GPR.
- `mem_wreg`  in  1  GPR write enable.
- `mem_wdata`  in  DATA_W  GPR write data.
- `mem_hi`, `mem_lo`  in  DATA_W  HI/LO results.
- `mem_we`  in  1  HI/LO write enable.
- `mem_flags`  in  FLAGS_W  flags value.
- `wb_valid`  out  1  output beat valid.
- `wb_ready`  in  1  writeback consumes beat.
- `wb_wd`, `wb_wreg`, `wb_wdata`, `wb_hi`, `wb_lo`, `wb_we`, `wb_flags`  out  widths as inputs  writeback payload.
- `occupancy`  out  2  held beats, 0..2.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `wb_valid & !wb_ready`.

## Operation
- Storage: main entry (drives `wb_*`) and skid entry. Each entry holds the full payload.
- `in_fire = mem_valid & mem_ready`; `out_fire = wb_valid & wb_ready`.
- States: EMPTY (occ 0), ONE (main valid), TWO (main + skid valid).
- `mem_ready = (state != TWO)`. `wb_valid = (state != EMPTY)`.
- Transitions, evaluated in priority order:
  - `rst`: go to EMPTY; clear both entries to zero; clear `stall_cnt`.
  - `flush`: go to EMPTY. A beat offered in the same cycle is dropped. Payload registers may keep stale data. `stall_cnt` is not cleared.
  - From EMPTY: on `in_fire`, main <= input and go to ONE.
  - From ONE:
    - `in_fire & wb_ready`: main <= input; stay in ONE.
    - `in_fire & !wb_ready`: skid <= input; go to TWO.
    - `!in_fire & wb_ready`: go to EMPTY.
    - Otherwise hold.
  - From TWO (no `in_fire` is possible): on `wb_ready`, main <= skid and go to ONE; otherwise hold.
- Write-enable gating: `wb_wreg = main.wreg & wb_valid` and `wb_we = main.we & wb_valid`. No GPR or HI/LO write may leak while the output is invalid or flushed.
- Other `wb_*` outputs show the main entry unchanged, including stale values when invalid.
- `stall_cnt` increments when `wb_valid & !wb_ready`, saturates at all-ones, and never wraps.
- Ordering is strict FIFO; no beat is duplicated or reordered.

## Timing
- Reset values:
  - `wb_wd`, `wb_wdata`, `wb_hi`, `wb_lo`, `wb_flags`: 0.
  - `wb_wreg`, `wb_we`, `wb_valid`: 0.
  - `occupancy`: 0; `stall_cnt`: 0.
  - `mem_ready`: 1 in the first cycle after reset is released.
- Latency: a beat accepted at edge N appears on `wb_*` with `wb_valid=1` after edge N.
- Back-pressure: after `wb_ready` falls, the stage absorbs at most one more beat. `mem_ready` falls the cycle after the skid fills.
- Recovery: when `wb_ready` returns in TWO, the skid beat is presented the next cycle and `mem_ready=1` in that same cycle.
- With `wb_ready` held at 1, throughput is one beat per cycle and `mem_ready` stays high.
- `flush` and `rst` asserted mid-stall: the next cycle has state EMPTY, `mem_ready=1`, `wb_valid=0`.
- No combinational path from `wb_ready` to `mem_ready`. Payload inputs only reach flops.

## Test plan
- **Reset:** hold `rst` for 2 cycles with random inputs. Required: all outputs zero, `mem_ready=1`, `wb_valid=0`, `occupancy=0`.
- **Streaming:** `wb_ready=1`; send beats with wd=1..8 and wdata=0x100+wd, one per cycle. Required: each beat appears exactly one cycle later, in order, with `occupancy=1` and `stall_cnt=0`.
- **Back-pressure:** drop `wb_ready` while beats A and B are sent back-to-back.
  - Required: `occupancy` goes to 2 and `mem_ready=0` the next cycle; `wb_*` holds A; `stall_cnt` increments each stalled cycle.
  - Then raise `wb_ready`: A, then B, with nothing lost.
- **Flush in TWO, with a new beat C offered in the same cycle.** Required: the next cycle has `wb_valid=0`, `wb_wreg=0`, `wb_we=0`, `occupancy=0`; C is never output; `mem_ready=1`.
- **Saturation:** `CNT_W=4`; stall for 20 cycles. Required: `stall_cnt` stops at 15 and does not wrap.
- **Write-enable gating:** send a beat with `wreg=1`, `we=1`, consume it, then leave the stage idle. Required: `wb_wreg` and `wb_we` are 0 while idle, even though the stale `wb_wd` and `wb_wdata` stay visible.

Source files
------------

// File: rtl/mem_wb_skid.sv
// ---------------------------------------------------------------------------
// mem_wb_skid
// MEM/WB pipeline boundary with a two-entry skid buffer. It carries the full
// writeback payload (GPR, HI/LO, flags) from MEM to writeback. It also has a
// synchronous stage flush and a saturating stall counter. Every output,
// including mem_ready, comes straight from a flop. As a result wb_ready never
// reaches mem_ready through combinational logic.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   flush             drop every held beat (and any beat offered this cycle)
//   mem_valid/ready   upstream handshake (MEM -> this stage)
//   mem_wd..mem_flags upstream writeback payload
//   wb_valid/ready    downstream handshake (this stage -> writeback)
//   wb_wd..wb_flags   downstream payload; wb_wreg/wb_we gated by wb_valid
//   occupancy         number of held beats, 0..2
//   stall_cnt         saturating count of cycles with wb_valid & !wb_ready
// ---------------------------------------------------------------------------
module mem_wb_skid #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned FLAGS_W = 32,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,

   input  logic               mem_valid,
   output logic               mem_ready,
   input  logic [ADDR_W-1:0]  mem_wd,
   input  logic               mem_wreg,
   input  logic [DATA_W-1:0]  mem_wdata,
   input  logic [DATA_W-1:0]  mem_hi,
   input  logic [DATA_W-1:0]  mem_lo,
   input  logic               mem_we,
   input  logic [FLAGS_W-1:0] mem_flags,

   output logic               wb_valid,
   input  logic               wb_ready,
   output logic [ADDR_W-1:0]  wb_wd,
   output logic               wb_wreg,
   output logic [DATA_W-1:0]  wb_wdata,
   output logic [DATA_W-1:0]  wb_hi,
   output logic [DATA_W-1:0]  wb_lo,
   output logic               wb_we,
   output logic [FLAGS_W-1:0] wb_flags,

   output logic [1:0]         occupancy,
   output logic [CNT_W-1:0]   stall_cnt
);

   // One writeback beat; both storage entries hold a full copy.
   typedef struct packed {
      logic [ADDR_W-1:0]  wd;
      logic               wreg;
      logic [DATA_W-1:0]  wdata;
      logic [DATA_W-1:0]  hi;
      logic [DATA_W-1:0]  lo;
      logic               we;
      logic [FLAGS_W-1:0] flags;
   } beat_t;

   // The encoding equals the number of held beats, so occupancy is the state.
   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_TWO   = 2'd2;

   logic [1:0]       state_q;
   logic [1:0]       state_n;
   beat_t            main_q;
   beat_t            main_n;
   beat_t            skid_q;
   beat_t            skid_n;
   beat_t            in_beat;
   logic [CNT_W-1:0] cnt_n;
   logic             in_fire;
   logic             stall;

   // Gather the upstream payload into one beat.
   always_comb begin
      in_beat       = '0;
      in_beat.wd    = mem_wd;
      in_beat.wreg  = mem_wreg;
      in_beat.wdata = mem_wdata;
      in_beat.hi    = mem_hi;
      in_beat.lo    = mem_lo;
      in_beat.we    = mem_we;
      in_beat.flags = mem_flags;
   end

   // mem_ready and wb_valid are flops, so both handshakes are flop-driven.
   assign in_fire = mem_valid & mem_ready;
   assign stall   = wb_valid & ~wb_ready;

   // Next state, entry updates and stall-counter update.
   always_comb begin
      state_n = state_q;
      main_n  = main_q;
      skid_n  = skid_q;
      cnt_n   = stall_cnt;

      // The counter keeps running through a flush; only rst clears it.
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
         cnt_n = stall_cnt + CNT_W'(1);
      end

      if (flush) begin
         // Payload stays stale; a beat offered in this cycle is dropped.
         state_n = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (in_fire) begin
                  main_n  = in_beat;
                  state_n = S_ONE;
               end
            end
            S_ONE: begin
               if (in_fire && wb_ready) begin
                  main_n = in_beat;
               end else if (in_fire) begin
                  skid_n  = in_beat;
                  state_n = S_TWO;
               end else if (wb_ready) begin
                  state_n = S_EMPTY;
               end
            end
            S_TWO: begin
               // mem_ready is low here, so no beat can enter.
               if (wb_ready) begin
                  main_n  = skid_q;
                  state_n = S_ONE;
               end
            end
            default: begin
               state_n = S_EMPTY;
            end
         endcase
      end
   end

   // State, storage and registered handshake/status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_EMPTY;
         main_q    <= '0;
         skid_q    <= '0;
         stall_cnt <= '0;
         mem_ready <= 1'b1;
         wb_valid  <= 1'b0;
         wb_wreg   <= 1'b0;
         wb_we     <= 1'b0;
         occupancy <= 2'd0;
      end else begin
         state_q   <= state_n;
         main_q    <= main_n;
         skid_q    <= skid_n;
         stall_cnt <= cnt_n;
         mem_ready <= (state_n != S_TWO);
         wb_valid  <= (state_n != S_EMPTY);
         // Gate the write enables so no write leaks while invalid or flushed.
         wb_wreg   <= main_n.wreg & (state_n != S_EMPTY);
         wb_we     <= main_n.we   & (state_n != S_EMPTY);
         occupancy <= state_n;
      end
   end

   // The data fields show the main entry as is, stale or not.
   assign wb_wd    = main_q.wd;
   assign wb_wdata = main_q.wdata;
   assign wb_hi    = main_q.hi;
   assign wb_lo    = main_q.lo;
   assign wb_flags = main_q.flags;

endmodule

// File: tb/tb_mem_wb_skid.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_skid
// Directed and randomized bench for mem_wb_skid (CNT_W=4). A queue-based
// reference model predicts every output after each clock edge.
// ---------------------------------------------------------------------------
module tb_mem_wb_skid;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned FLAGS_W = 32;
   localparam int unsigned CNT_W   = 4;

   typedef struct packed {
      logic [ADDR_W-1:0]  wd;
      logic               wreg;
      logic [DATA_W-1:0]  wdata;
      logic [DATA_W-1:0]  hi;
      logic [DATA_W-1:0]  lo;
      logic               we;
      logic [FLAGS_W-1:0] flags;
   } beat_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               flush;
   logic               mem_valid;
   logic               mem_ready;
   logic [ADDR_W-1:0]  mem_wd;
   logic               mem_wreg;
   logic [DATA_W-1:0]  mem_wdata;
   logic [DATA_W-1:0]  mem_hi;
   logic [DATA_W-1:0]  mem_lo;
   logic               mem_we;
   logic [FLAGS_W-1:0] mem_flags;
   logic               wb_valid;
   logic               wb_ready;
   logic [ADDR_W-1:0]  wb_wd;
   logic               wb_wreg;
   logic [DATA_W-1:0]  wb_wdata;
   logic [DATA_W-1:0]  wb_hi;
   logic [DATA_W-1:0]  wb_lo;
   logic               wb_we;
   logic [FLAGS_W-1:0] wb_flags;
   logic [1:0]         occupancy;
   logic [CNT_W-1:0]   stall_cnt;

   mem_wb_skid #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .FLAGS_W(FLAGS_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .mem_valid(mem_valid),
      .mem_ready(mem_ready),
      .mem_wd   (mem_wd),
      .mem_wreg (mem_wreg),
      .mem_wdata(mem_wdata),
      .mem_hi   (mem_hi),
      .mem_lo   (mem_lo),
      .mem_we   (mem_we),
      .mem_flags(mem_flags),
      .wb_valid (wb_valid),
      .wb_ready (wb_ready),
      .wb_wd    (wb_wd),
      .wb_wreg  (wb_wreg),
      .wb_wdata (wb_wdata),
      .wb_hi    (wb_hi),
      .wb_lo    (wb_lo),
      .wb_we    (wb_we),
      .wb_flags (wb_flags),
      .occupancy(occupancy),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int npass = 0;
   int ntotal = 0;

   // Reference model: a FIFO of at most two beats, plus the beat last shown.
   beat_t m_q[$];
   beat_t m_disp;
   int    m_cnt;

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      ntotal++;
      assert (obs === exp) begin
         npass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic beat_t rand_beat();
      beat_t b;
      b.wd    = ADDR_W'($urandom);
      b.wreg  = 1'($urandom);
      b.wdata = $urandom;
      b.hi    = $urandom;
      b.lo    = $urandom;
      b.we    = 1'($urandom);
      b.flags = $urandom;
      return b;
   endfunction

   task automatic drive(input logic v, input beat_t b);
      mem_valid = v;
      mem_wd    = b.wd;
      mem_wreg  = b.wreg;
      mem_wdata = b.wdata;
      mem_hi    = b.hi;
      mem_lo    = b.lo;
      mem_we    = b.we;
      mem_flags = b.flags;
   endtask

   // Advance one clock edge, update the model, then check every output.
   task automatic step();
      bit    acc;
      bit    pop;
      beat_t in_b;
      @(posedge clk);
      in_b = '{wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata, hi: mem_hi,
               lo: mem_lo, we: mem_we, flags: mem_flags};
      acc = mem_valid && (m_q.size() < 2);
      pop = (m_q.size() > 0) && wb_ready;
      if (rst) begin
         m_q.delete();
         m_disp = '0;
         m_cnt  = 0;
      end else begin
         if (m_q.size() > 0 && !wb_ready && m_cnt < 15) m_cnt++;
         if (flush) begin
            m_q.delete();
         end else begin
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back(in_b);
         end
         if (m_q.size() > 0) m_disp = m_q[0];
      end
      #1;
      chk("wb_valid",  160'(wb_valid),  160'(m_q.size() > 0));
      chk("mem_ready", 160'(mem_ready), 160'(m_q.size() < 2));
      chk("occupancy", 160'(occupancy), 160'(m_q.size()));
      chk("stall_cnt", 160'(stall_cnt), 160'(m_cnt));
      chk("payload", 160'({wb_wd, wb_wdata, wb_hi, wb_lo, wb_flags}),
          160'({m_disp.wd, m_disp.wdata, m_disp.hi, m_disp.lo, m_disp.flags}));
      chk("wb_wreg", 160'(wb_wreg), 160'(m_disp.wreg && m_q.size() > 0));
      chk("wb_we",   160'(wb_we),   160'(m_disp.we && m_q.size() > 0));
   endtask

   initial begin
      beat_t b;
      beat_t g;

      // Reset held for two cycles under random inputs.
      rst = 1'b1; flush = 1'($urandom); wb_ready = 1'($urandom);
      drive(1'($urandom), rand_beat());
      step();
      flush = 1'($urandom); wb_ready = 1'($urandom);
      drive(1'($urandom), rand_beat());
      step();
      chk("rst_occ0",   160'(occupancy), 160'(0));
      chk("rst_ready1", 160'(mem_ready), 160'(1));
      chk("rst_wd0",    160'(wb_wd),     160'(0));
      rst = 1'b0; flush = 1'b0;

      // Streaming with wb_ready held high.
      wb_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         b = rand_beat();
         b.wd = ADDR_W'(i);
         b.wdata = 32'h100 + 32'(i);
         drive(1'b1, b);
         step();
         chk("stream_wd",  160'(wb_wd),     160'(i));
         chk("stream_occ", 160'(occupancy), 160'(1));
      end
      drive(1'b0, rand_beat());
      step();

      // Back-pressure: A then B while wb_ready is low, C refused.
      b = rand_beat(); b.wd = 5'd10;
      drive(1'b1, b);
      wb_ready = 1'b0;
      step();
      b = rand_beat(); b.wd = 5'd11;
      drive(1'b1, b);
      step();
      chk("bp_occ2",   160'(occupancy), 160'(2));
      chk("bp_ready0", 160'(mem_ready), 160'(0));
      chk("bp_holdA",  160'(wb_wd),     160'(10));
      b = rand_beat(); b.wd = 5'd12;
      drive(1'b1, b);
      step();
      step();
      drive(1'b0, rand_beat());
      wb_ready = 1'b1;
      step();
      chk("bp_B",      160'(wb_wd),     160'(11));
      chk("bp_ready1", 160'(mem_ready), 160'(1));
      step();

      // Flush in TWO with a new beat offered the same cycle.
      wb_ready = 1'b0;
      drive(1'b1, rand_beat());
      step();
      drive(1'b1, rand_beat());
      step();
      b = rand_beat(); b.wd = 5'd13; b.wreg = 1'b1; b.we = 1'b1;
      drive(1'b1, b);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, rand_beat());
      chk("fl_valid0", 160'(wb_valid),  160'(0));
      chk("fl_occ0",   160'(occupancy), 160'(0));
      chk("fl_ready1", 160'(mem_ready), 160'(1));
      step();

      // Saturation: stall for 20 cycles with CNT_W=4.
      rst = 1'b1;
      step();
      rst = 1'b0;
      drive(1'b1, rand_beat());
      step();
      drive(1'b0, rand_beat());
      for (int i = 0; i < 20; i++) step();
      chk("sat_15", 160'(stall_cnt), 160'(15));

      // Write-enable gating on an idle, stale output.
      wb_ready = 1'b1;
      step();
      g = rand_beat(); g.wreg = 1'b1; g.we = 1'b1;
      drive(1'b1, g);
      step();
      chk("we_live", 160'({wb_wreg, wb_we}), 160'(2'b11));
      drive(1'b0, rand_beat());
      for (int i = 0; i < 3; i++) step();
      chk("we_idle_wreg", 160'(wb_wreg),  160'(0));
      chk("we_idle_we",   160'(wb_we),    160'(0));
      chk("we_stale_wd",  160'(wb_wdata), 160'(g.wdata));

      // Randomized traffic with occasional flush and reset.
      for (int i = 0; i < 400; i++) begin
         rst      = ($urandom_range(0, 63) == 0);
         flush    = ($urandom_range(0, 15) == 0);
         wb_ready = ($urandom_range(0, 2) != 0);
         drive(1'($urandom), rand_beat());
         step();
      end

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
